// File: rtl/apb_reg_pkg.sv
// ============================================================================
// Module   : apb_reg_pkg
// Purpose  : Shared types, constants and address-map helpers for apb_reg_bank
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_reg_pkg;

    localparam int c_wait_cnt_w = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    // The three special registers sit directly above the control registers.
    function automatic logic [31:0] status_off(input int nregs);
        return 32'(4 * nregs);
    endfunction

    function automatic logic [31:0] irq_stat_off(input int nregs);
        return 32'(4 * nregs + 4);
    endfunction

    function automatic logic [31:0] irq_en_off(input int nregs);
        return 32'(4 * nregs + 8);
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_reg_bank_if.sv
// ============================================================================
// Module   : apb_reg_bank_if
// Purpose  : APB bus bundle with master and slave views
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_reg_bank_if #(
    parameter int AW = 8,
    parameter int DW = 32
) ();

    logic [AW-1:0]   paddr;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
    logic            pready;
    logic [DW-1:0]   prdata;
    logic            pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );

endinterface

`default_nettype wire

// File: rtl/apb_wait_ctrl.sv
// ============================================================================
// Module   : apb_wait_ctrl
// Purpose  : APB transfer FSM, wait-state counter and pready generation
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_wait_ctrl
    import apb_reg_pkg::*;
#(
    parameter int WAIT = 0
) (
    input  wire logic pclk,
    input  wire logic presetn,
    input  wire logic i_psel,
    input  wire logic i_penable,
    output logic      o_pready
);

    localparam logic [c_wait_cnt_w-1:0] c_wait_val = WAIT[c_wait_cnt_w-1:0];

    apb_state_e              r_state;
    logic [c_wait_cnt_w-1:0] r_count;
    logic                    r_armed;

    logic w_setup;
    logic w_access;
    logic w_pready;

    assign w_setup  = i_psel & ~i_penable;
    assign w_access = i_psel &  i_penable;

    // r_armed records that a setup phase was seen, so an access phase that
    // straddles a reset can never complete.
    assign w_pready = w_access & r_armed & (r_count == c_wait_val);
    assign o_pready = w_pready;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_armed <= 1'b0;
        end else begin
            if (w_setup) begin
                r_count <= '0;
                r_armed <= 1'b1;
            end else if (w_pready || !i_psel) begin
                r_armed <= 1'b0;
            end else if (w_access && r_armed) begin
                r_count <= r_count + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_access && r_armed && !w_pready)
                        r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_pready || !w_access)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_reg_bank.sv
// ============================================================================
// Module   : apb_reg_bank
// Purpose  : APB register bank with control regs, STATUS and W1C interrupts
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_reg_bank
    import apb_reg_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 8,
    parameter int NREGS = 8,
    parameter int WAIT  = 0
) (
    input  wire logic             pclk,
    input  wire logic             presetn,
    apb_reg_bank_if.slave         apb,
    input  wire logic [DW-1:0]    status_i,
    input  wire logic [DW-1:0]    irq_evt_i,
    output logic [NREGS*DW-1:0]   ctrl_o,
    output logic                  irq_o
);

    logic [DW-1:0] r_ctrl [NREGS];
    logic [DW-1:0] r_irq_stat;
    logic [DW-1:0] r_irq_en;
    logic          r_irq;

    logic [31:0]   w_addr;
    logic [31:0]   w_word;
    logic          w_aligned;
    logic          w_hit_ctrl;
    logic          w_hit_status;
    logic          w_hit_stat;
    logic          w_hit_en;
    logic          w_err;
    logic          w_pready;
    logic          w_commit;
    logic [DW-1:0] w_mask;
    logic [DW-1:0] w_clr;
    logic [DW-1:0] w_rdata;

    apb_wait_ctrl #(
        .WAIT (WAIT)
    ) u_wait_ctrl (
        .pclk      (pclk),
        .presetn   (presetn),
        .i_psel    (apb.psel),
        .i_penable (apb.penable),
        .o_pready  (w_pready)
    );

    assign w_addr       = 32'(apb.paddr);
    assign w_word       = w_addr >> 2;
    assign w_aligned    = (w_addr[1:0] == 2'b00);
    assign w_hit_ctrl   = (w_word < 32'(NREGS));
    assign w_hit_status = (w_addr == status_off(NREGS));
    assign w_hit_stat   = (w_addr == irq_stat_off(NREGS));
    assign w_hit_en     = (w_addr == irq_en_off(NREGS));

    assign w_err = ~w_aligned
                 | ~(w_hit_ctrl | w_hit_status | w_hit_stat | w_hit_en)
                 | (w_hit_status & apb.pwrite);

    assign w_commit = w_pready & apb.pwrite & ~w_err;

    for (genvar b = 0; b < DW/8; b++) begin : g_mask
        assign w_mask[b*8 +: 8] = {8{apb.pstrb[b]}};
    end

    assign w_clr = (w_commit && w_hit_stat) ? (apb.pwdata & w_mask) : '0;

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (w_word == 32'(i))
                w_rdata = r_ctrl[i];
        end
        if (w_hit_status) w_rdata = status_i;
        if (w_hit_stat)   w_rdata = r_irq_stat;
        if (w_hit_en)     w_rdata = r_irq_en;
    end

    // pready is held low by the controller while in reset, which also
    // forces pslverr and prdata to zero.
    assign apb.pready  = w_pready;
    assign apb.pslverr = w_pready & w_err;
    assign apb.prdata  = (w_pready && !apb.pwrite && !w_err) ? w_rdata : '0;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < NREGS; i++)
                r_ctrl[i] <= '0;
            r_irq_stat <= '0;
            r_irq_en   <= '0;
            r_irq      <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_commit && w_hit_ctrl && (w_word == 32'(i)))
                    r_ctrl[i] <= (r_ctrl[i] & ~w_mask) | (apb.pwdata & w_mask);
            end
            // Events are OR-ed after the clear so a simultaneous set wins.
            r_irq_stat <= (r_irq_stat & ~w_clr) | irq_evt_i;
            if (w_commit && w_hit_en)
                r_irq_en <= (r_irq_en & ~w_mask) | (apb.pwdata & w_mask);
            r_irq <= |(r_irq_stat & r_irq_en);
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_ctrl_out
        assign ctrl_o[i*DW +: DW] = r_ctrl[i];
    end

    assign irq_o = r_irq;

endmodule

`default_nettype wire
